// File: rtl/reg_dst_sel_pipe.sv
// reg_dst_sel_pipe
// Picks one of NUM_IN register-destination channels and passes it into a
// registered, valid/ready output stage. The stage has two entries (head and
// skid), so upstream can be stalled without a combinational ready path.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   data_in    packed channels, channel i at [i*WIDTH +: WIDTH]
//   sel        channel select, sampled together with in_valid
//   in_valid   upstream offers a beat
//   in_ready   stage can take a beat (registered: skid entry is free)
//   flush      drop everything buffered plus any beat offered this cycle
//   data_out   head value; keeps its last value while out_valid is low
//   out_valid  head holds a beat
//   out_ready  downstream takes the head beat
//   sel_err    head beat came from an out-of-range select
//   err_count  saturating count of accepted out-of-range selects
module reg_dst_sel_pipe #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        data_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    output logic [CNT_W-1:0]        err_count
);

    // Every code the select can carry gets a slot; unused slots read zero
    // but are never chosen because they are flagged illegal.
    localparam int NUM_SLOT = 1 << SEL_W;

    logic [WIDTH-1:0] chan [NUM_SLOT];

    generate
        for (genvar gi = 0; gi < NUM_SLOT; gi++) begin : g_chan
            if (gi < NUM_IN) begin : g_live
                assign chan[gi] = data_in[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign chan[gi] = '0;
            end
        end
    endgenerate

    logic [WIDTH-1:0] head_data_reg;
    logic             head_err_reg;
    logic             head_valid_reg;
    logic [WIDTH-1:0] skid_data_reg;
    logic             skid_err_reg;
    logic             skid_valid_reg;
    logic [WIDTH-1:0] hold_reg;
    logic [CNT_W-1:0] err_count_reg;

    logic             legal;
    logic [WIDTH-1:0] beat_data;
    logic             accept;
    logic             pop;

    assign in_ready  = !skid_valid_reg;
    assign accept    = in_valid && in_ready;
    assign pop       = head_valid_reg && out_ready;
    assign legal     = (int'(sel) < NUM_IN);
    // Illegal selects repeat the last legal destination instead of a junk value.
    assign beat_data = legal ? chan[sel] : hold_reg;

    assign data_out  = head_data_reg;
    assign out_valid = head_valid_reg;
    assign sel_err   = head_err_reg;
    assign err_count = err_count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_data_reg  <= '0;
            head_err_reg   <= 1'b0;
            head_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_err_reg   <= 1'b0;
            skid_valid_reg <= 1'b0;
            hold_reg       <= '0;
            err_count_reg  <= '0;
        end else if (flush) begin
            // head_data_reg is left alone so data_out keeps its last value.
            head_err_reg   <= 1'b0;
            head_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                if (legal) begin
                    hold_reg <= beat_data;
                end else if (err_count_reg != {CNT_W{1'b1}}) begin
                    err_count_reg <= err_count_reg + 1'b1;
                end
            end

            // accept implies the skid is empty, so a full skid never
            // coincides with a new beat.
            if (pop && skid_valid_reg) begin
                head_data_reg  <= skid_data_reg;
                head_err_reg   <= skid_err_reg;
                head_valid_reg <= 1'b1;
                skid_valid_reg <= 1'b0;
                skid_err_reg   <= 1'b0;
            end else if (pop || !head_valid_reg) begin
                head_valid_reg <= accept;
                if (accept) begin
                    head_data_reg <= beat_data;
                    head_err_reg  <= !legal;
                end else begin
                    head_err_reg  <= 1'b0;
                end
            end else if (accept) begin
                skid_data_reg  <= beat_data;
                skid_err_reg   <= !legal;
                skid_valid_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_dst_sel_pipe.sv
module tb_reg_dst_sel_pipe;

    localparam int WIDTH  = 5;
    localparam int NUM_IN = 3;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_IN*WIDTH-1:0] data_in;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        data_out;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;
    logic [CNT_W-1:0]        err_count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    reg_dst_sel_pipe #(
        .WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
        .sel_err(sel_err), .err_count(err_count)
    );

    typedef struct {
        logic             rst_n;
        logic             flush;
        logic             in_valid;
        logic [SEL_W-1:0] sel;
        logic [4:0]       ch0;
        logic             out_ready;
        logic             ov;
        logic             ir;
        logic [4:0]       dout;
        logic             serr;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    vec_t vecs[$];

    // ch2=31 and ch1=12 are fixed; ch0 varies per vector.
    task automatic add(input logic r, input logic f, input logic iv, input logic [SEL_W-1:0] s,
                       input logic [4:0] c0, input logic ordy, input logic ov, input logic ir,
                       input logic [4:0] d, input logic e, input logic [CNT_W-1:0] c);
        vec_t v;
        v.rst_n = r; v.flush = f; v.in_valid = iv; v.sel = s; v.ch0 = c0; v.out_ready = ordy;
        v.ov = ov; v.ir = ir; v.dout = d; v.serr = e; v.cnt = c;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        rst_n = v.rst_n; flush = v.flush; in_valid = v.in_valid; sel = v.sel;
        out_ready = v.out_ready; data_in = {5'd31, 5'd12, v.ch0};
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int i, input vec_t v);
        check("out_valid", i, 32'(out_valid), 32'(v.ov));
        check("in_ready",  i, 32'(in_ready),  32'(v.ir));
        check("data_out",  i, 32'(data_out),  32'(v.dout));
        check("sel_err",   i, 32'(sel_err),   32'(v.serr));
        check("err_count", i, 32'(err_count), 32'(v.cnt));
        $display("[TB] step %0d rst_n=%0b flush=%0b iv=%0b sel=%0d ordy=%0b -> ov=%0b ir=%0b dout=%0d serr=%0b cnt=%0d",
                 i, v.rst_n, v.flush, v.in_valid, v.sel, v.out_ready,
                 out_valid, in_ready, data_out, sel_err, err_count);
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; sel = '0; out_ready = 1'b0; data_in = '0;

        //   rst flush iv sel ch0 ordy | ov ir dout serr cnt
        // reset, then legal stream 7,12,31
        add(0, 0, 0, 0, 7, 1,   0, 1, 0,  0, 0);
        add(1, 0, 1, 0, 7, 1,   1, 1, 7,  0, 0);
        add(1, 0, 1, 1, 7, 1,   1, 1, 12, 0, 0);
        add(1, 0, 1, 2, 7, 1,   1, 1, 31, 0, 0);
        add(1, 0, 0, 0, 7, 1,   0, 1, 31, 0, 0);
        // illegal select repeats last legal value
        add(1, 0, 1, 1, 7, 1,   1, 1, 12, 0, 0);
        add(1, 0, 1, 3, 7, 1,   1, 1, 12, 1, 1);
        add(1, 0, 0, 0, 7, 1,   0, 1, 12, 0, 1);
        // illegal select straight after reset gives 0
        add(0, 0, 0, 0, 7, 1,   0, 1, 0,  0, 0);
        add(1, 0, 1, 3, 7, 1,   1, 1, 0,  1, 1);
        add(1, 0, 0, 0, 7, 1,   0, 1, 0,  0, 1);
        // back-pressure: 1,2 absorbed, 3 stalled, then drained in order
        add(1, 0, 1, 0, 1, 0,   1, 1, 1,  0, 1);
        add(1, 0, 1, 0, 2, 0,   1, 0, 1,  0, 1);
        add(1, 0, 1, 0, 3, 0,   1, 0, 1,  0, 1);
        add(1, 0, 1, 0, 3, 1,   1, 1, 2,  0, 1);
        add(1, 0, 1, 0, 3, 1,   1, 1, 3,  0, 1);
        add(1, 0, 0, 0, 3, 1,   0, 1, 3,  0, 1);
        // flush with both entries full
        add(1, 0, 1, 0, 4, 0,   1, 1, 4,  0, 1);
        add(1, 0, 1, 0, 5, 0,   1, 0, 4,  0, 1);
        add(1, 1, 1, 3, 5, 0,   0, 1, 4,  0, 1);
        // flush with an acceptable illegal beat: dropped, count unchanged
        add(1, 0, 1, 0, 6, 0,   1, 1, 6,  0, 1);
        add(1, 1, 1, 3, 6, 0,   0, 1, 6,  0, 1);
        add(1, 0, 0, 0, 6, 1,   0, 1, 6,  0, 1);
        add(1, 0, 1, 3, 6, 1,   1, 1, 6,  1, 2);
        add(1, 0, 0, 0, 6, 1,   0, 1, 6,  0, 2);
        // reset with a full buffer clears everything including hold
        add(1, 0, 1, 1, 6, 0,   1, 1, 12, 0, 2);
        add(1, 0, 1, 1, 6, 0,   1, 0, 12, 0, 2);
        add(0, 0, 1, 1, 6, 0,   0, 1, 0,  0, 0);
        add(1, 0, 1, 3, 6, 1,   1, 1, 0,  1, 1);
        add(1, 0, 0, 0, 6, 1,   0, 1, 0,  0, 1);

        foreach (vecs[i]) begin
            v = vecs[i];
            step(v);
            check_all(i, v);
        end

        // counter saturation with CNT_W=2: 1,2,3,3,3
        add(0, 0, 0, 0, 7, 1,   0, 1, 0, 0, 0);
        v = vecs[vecs.size()-1];
        step(v);
        check_all(100, v);
        for (int k = 0; k < 5; k++) begin
            int exp_cnt;
            exp_cnt = (k + 1 > 3) ? 3 : k + 1;
            v.rst_n = 1'b1; v.in_valid = 1'b1; v.sel = 2'd3; v.out_ready = 1'b1;
            v.ov = 1'b1; v.ir = 1'b1; v.dout = 5'd0; v.serr = 1'b1; v.cnt = CNT_W'(exp_cnt);
            step(v);
            check_all(101 + k, v);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reg_dst_sel_pipe.md
Name: reg_dst_sel_pipe

Overview:
- Parametrised successor to the 3-way register-destination selector.
- NUM_IN-way, WIDTH-bit selection into a registered, flow-controlled output stage with 2-entry skid buffering, flush, and defined hold-last behaviour on illegal select.
- Illegal-select events are counted.
- Sits between ID/EX destination selection and the EX/MEM pipeline register, so stalls back-pressure cleanly and flushes kill in-flight destinations.

Parameters:
- WIDTH, 5, data width per channel (register index width)
- NUM_IN, 3, number of selectable channels (2..16)
- SEL_W, 2, select width; must satisfy 2^SEL_W >= NUM_IN
- CNT_W, 8, width of illegal-select counter

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- data_in  in  NUM_IN*WIDTH  packed channels; channel i at [i*WIDTH +: WIDTH]
- sel  in  SEL_W  channel select, sampled with in_valid
- in_valid  in  1  upstream has a beat
- in_ready  out  1  block can accept a beat
- flush  in  1  synchronous kill of all buffered beats
- data_out  out  WIDTH  selected value at output head
- out_valid  out  1  data_out valid
- out_ready  in  1  downstream consumes when high with out_valid
- sel_err  out  1  head beat was produced from an illegal select
- err_count  out  CNT_W  saturating count of accepted illegal-select beats

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at edge): out_valid=0, in_ready=1, data_out=0, sel_err=0, err_count=0, skid empty, hold register=0. Reset overrides flush and any handshake.
- Accept when in_valid && in_ready; pop when out_valid && out_ready.
- Selection on accept:
  - sel < NUM_IN: value = channel sel; hold register <= value; err flag 0.
  - sel >= NUM_IN: value = hold register (last legal accepted value, 0 after reset); hold unchanged; err flag 1; err_count += 1, saturating at 2^CNT_W-1.
- Storage is two entries, head (drives data_out/sel_err) and skid, with FIFO order.
  - Head empty or popping this cycle: accepted beat goes to head (or skid moves to head and new beat goes to skid).
  - Head full and not popping: accepted beat goes to skid.
- in_ready is registered: in_ready = !skid_full after the edge. No combinational path from out_ready to in_ready.
- Latency: accept at edge N gives out_valid at edge N (visible cycle N+1) when head is empty. Throughput is 1 beat/cycle under continuous out_ready.
- Back-pressure: with out_ready=0, at most 2 beats are absorbed, then in_ready=0. data_out and sel_err are stable while out_valid && !out_ready.
- Simultaneous accept and pop with full head and empty skid: new beat goes to head, skid stays empty.
- flush=1 at edge: head and skid cleared, out_valid=0, in_ready=1. A beat presented that cycle is dropped: no hold update, no err_count update. Hold register and err_count are otherwise preserved.
- sel_err is 0 whenever out_valid=0. data_out holds its last value when invalid.
- err_count never wraps.

Test Plan:
- Reset then legal stream: NUM_IN=3, data_in={ch2=31, ch1=12, ch0=7}, out_ready=1, sel=0,1,2 on consecutive cycles -> data_out 7,12,31 on consecutive cycles starting one cycle after first accept; sel_err=0; err_count=0.
- Illegal select hold: accept sel=1 (ch1=12), then sel=3 -> second beat data_out=12, sel_err=1, err_count=1. Same after reset with sel=3 first -> data_out=0, sel_err=1.
- Back-pressure: out_ready=0, offer 3 beats (ch0 values 1,2,3, sel=0) -> first 2 accepted, in_ready=0 on the 3rd. Raise out_ready -> outputs 1,2,3 in order, no loss or duplication.
- Flush with full buffer: 2 beats buffered, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1; dropped beat never appears; err_count unchanged even if the dropped beat had an illegal sel.
- Counter saturation: CNT_W=2, accept 5 illegal-select beats -> err_count 1,2,3,3,3.
- Reset mid-operation: buffer full, out_ready=0, pull rst_n low for one edge -> out_valid=0, in_ready=1, err_count=0, hold=0; next illegal sel yields data_out=0.
